// File: rtl/ec_pkg.sv
// Shared elliptic-curve field package.
// Holds the field constants used by the point double/add/affine stages,
// the affine-conversion FSM state type and a generic modular reduction helper.
package ec_pkg;

    localparam int FIELD_W = 4;
    localparam int FIELD_P = 7;

    typedef enum logic [2:0] {
        IDLE,
        INV_SQ,
        INV_MUL,
        MULX,
        MULY,
        DONE
    } state_t;

    // v mod m; callers size both operands to 32 bits and truncate the result.
    function automatic logic [31:0] mod_reduce(input logic [31:0] v, input logic [31:0] m);
        return v % m;
    endfunction

endpackage

// File: rtl/ff_mul_mod.sv
// Combinational modular multiplier over GF(P).
// Ports:
//   a, b : W-bit operands (expected < P)
//   p    : (a*b) mod P, W bits
module ff_mul_mod
    import ec_pkg::*;
#(
    parameter int W = FIELD_W,
    parameter int P = FIELD_P
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p
);

    logic [2*W-1:0] prod;

    assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    assign p    = W'(mod_reduce(32'(prod), 32'(P)));

endmodule

// File: rtl/ec_proj_to_affine.sv
// Projective (X:Y:Z) to affine (X/Z, Y/Z) conversion over GF(P).
// Z^-1 is computed as Z^(P-2) by MSB-first square-and-multiply on a single
// shared modular multiplier, then X and Y are each multiplied by it.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : input handshake for X1/Y1/Z1 (any W-bit value)
//   X1, Y1, Z1          : projective coordinates
//   out_valid, out_ready: output handshake
//   x_aff, y_aff        : affine coordinates in [0, P-1]
//   inf                 : point at infinity (Z mod P == 0)
module ec_proj_to_affine
    import ec_pkg::*;
#(
    parameter int W = FIELD_W,
    parameter int P = FIELD_P
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] X1,
    input  logic [W-1:0] Y1,
    input  logic [W-1:0] Z1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x_aff,
    output logic [W-1:0] y_aff,
    output logic         inf
);

    localparam int             EB = $clog2(P - 1);
    localparam int             KW = $clog2(EB + 1);
    localparam logic [EB-1:0]  E  = EB'(P - 2);

    function automatic logic [W-1:0] red(input logic [W-1:0] v);
        return W'(mod_reduce(32'(v), 32'(P)));
    endfunction

    state_t        state;
    logic [W-1:0]  acc;
    logic [W-1:0]  xr;
    logic [W-1:0]  yr;
    logic [W-1:0]  zr;
    logic [KW-1:0] k;

    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [W-1:0]  mul_p;
    logic [EB-1:0] e_shift;
    logic          e_bit;
    logic [W-1:0]  z_red;

    assign e_shift = E >> k;
    assign e_bit   = e_shift[0];
    assign z_red   = red(Z1);

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            INV_SQ:  begin mul_a = acc; mul_b = acc; end
            INV_MUL: begin mul_a = acc; mul_b = zr;  end
            MULX:    begin mul_a = xr;  mul_b = acc; end
            MULY:    begin mul_a = yr;  mul_b = acc; end
            default: ;
        endcase
    end

    ff_mul_mod #(.W(W), .P(P)) u_mul (
        .a(mul_a),
        .b(mul_b),
        .p(mul_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            xr        <= '0;
            yr        <= '0;
            zr        <= '0;
            k         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            x_aff     <= '0;
            y_aff     <= '0;
            inf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xr       <= red(X1);
                        yr       <= red(Y1);
                        zr       <= z_red;
                        in_ready <= 1'b0;
                        if (z_red == '0) begin
                            // Infinity short-cuts straight to a valid result.
                            x_aff     <= '0;
                            y_aff     <= '0;
                            inf       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            acc   <= W'(1);
                            k     <= KW'(EB - 1);
                            state <= INV_SQ;
                        end
                    end
                end
                INV_SQ: begin
                    acc   <= mul_p;
                    state <= INV_MUL;
                end
                INV_MUL: begin
                    // Always one cycle whether or not the bit is set: fixed latency.
                    if (e_bit) acc <= mul_p;
                    if (k == '0) begin
                        state <= MULX;
                    end else begin
                        k     <= k - 1'b1;
                        state <= INV_SQ;
                    end
                end
                MULX: begin
                    x_aff <= mul_p;
                    state <= MULY;
                end
                MULY: begin
                    y_aff <= mul_p;
                    inf   <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    // First DONE cycle raises out_valid; afterwards wait for the consumer.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ec_proj_to_affine.sv
module tb_ec_proj_to_affine;

    localparam int W = 4;
    localparam int P = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] X1 = '0;
    logic [W-1:0] Y1 = '0;
    logic [W-1:0] Z1 = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] x_aff;
    logic [W-1:0] y_aff;
    logic         inf;

    int errors = 0;
    int checks = 0;

    // Model expectations for the point currently in flight.
    int exp_x = 0;
    int exp_y = 0;
    int exp_inf = 0;

    always #5 clk = ~clk;

    ec_proj_to_affine #(.W(W), .P(P)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .X1(X1),
        .Y1(Y1),
        .Z1(Z1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_aff(x_aff),
        .y_aff(y_aff),
        .inf(inf)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Field inverse by exhaustive search: independent of any exponentiation.
    function automatic int inv_mod(input int z);
        for (int i = 1; i < P; i++)
            if ((z * i) % P == 1) return i;
        return 0;
    endfunction

    task automatic set_model(input int x, input int y, input int z);
        if (z % P == 0) begin
            exp_x = 0; exp_y = 0; exp_inf = 1;
        end else begin
            exp_x = ((x % P) * inv_mod(z % P)) % P;
            exp_y = ((y % P) * inv_mod(z % P)) % P;
            exp_inf = 0;
        end
    endtask

    // Compare process: whenever a result is presented it must match the model.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("model_x", int'(x_aff), exp_x);
            check("model_y", int'(y_aff), exp_y);
            check("model_inf", int'(inf), exp_inf);
        end
    end

    // Launch one point, measure latency, check hand-computed results.
    task automatic run_point(input int x, input int y, input int z,
                             input int hx, input int hy, input int hinf,
                             input int hlat, input string tag);
        int cnt;
        set_model(x, y, z);
        @(negedge clk);
        X1 = W'(x); Y1 = W'(y); Z1 = W'(z);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_ready_low"}, int'(in_ready), 0);
        cnt = 0;
        while (!out_valid && cnt < 30) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_latency"}, cnt, hlat);
        check({tag, "_x"}, int'(x_aff), hx);
        check({tag, "_y"}, int'(y_aff), hy);
        check({tag, "_inf"}, int'(inf), hinf);
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, int'(out_valid), 0);
        check({tag, "_ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        int cnt;
        logic [W-1:0] hold_x, hold_y;

        #12;
        check("rst_ready", int'(in_ready), 1);
        check("rst_valid", int'(out_valid), 0);
        check("rst_x", int'(x_aff), 0);
        check("rst_y", int'(y_aff), 0);
        check("rst_inf", int'(inf), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_point(2, 1, 1, 2, 1, 0, 9, "p211");
        run_point(1, 6, 5, 3, 4, 0, 9, "p165");
        run_point(4, 2, 3, 6, 3, 0, 9, "p423");
        run_point(9, 12, 10, 3, 4, 0, 9, "p_big");
        run_point(3, 5, 0, 0, 0, 1, 0, "z0");
        run_point(3, 5, 7, 0, 0, 1, 0, "z7");
        run_point(6, 6, 6, 1, 1, 0, 9, "p666");

        // Backpressure: hold result for 5 cycles and offer a new point meanwhile.
        set_model(1, 6, 5);
        @(negedge clk);
        X1 = 4'd1; Y1 = 4'd6; Z1 = 4'd5;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 30) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("bp_latency", cnt, 9);
        hold_x = x_aff;
        hold_y = y_aff;
        X1 = 4'd2; Y1 = 4'd1; Z1 = 4'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", int'(out_valid), 1);
            check("bp_ready", int'(in_ready), 0);
            check("bp_x", int'(x_aff), int'(hold_x));
            check("bp_y", int'(y_aff), int'(hold_y));
        end
        check("bp_x_val", int'(x_aff), 3);
        check("bp_y_val", int'(y_aff), 4);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", int'(out_valid), 0);
        check("bp_inf_kept", int'(inf), 0);
        check("bp_idle", int'(in_ready), 1);

        // out_ready pulses while idle do nothing.
        @(posedge clk); #1;
        check("idle_valid", int'(out_valid), 0);

        // Reset in the middle of inversion.
        set_model(2, 1, 1);
        @(negedge clk);
        X1 = 4'd2; Y1 = 4'd1; Z1 = 4'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("ar_ready", int'(in_ready), 1);
        check("ar_valid", int'(out_valid), 0);
        check("ar_x", int'(x_aff), 0);
        check("ar_y", int'(y_aff), 0);
        check("ar_inf", int'(inf), 0);
        repeat (2) @(posedge clk);
        #1;
        check("ar_hold_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_point(2, 1, 1, 2, 1, 0, 9, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
